// File: rtl/adc_link_pkg.sv
// adc_link_pkg
//   Constants shared by the ADC serializer, the ADC deserializer and their benches:
//   word/lane geometry, the pattern_sel encodings and the alternating test words.
package adc_link_pkg;

   localparam int unsigned ADC_WORD_W    = 10;
   localparam int unsigned ADC_LANES     = 4;
   localparam int unsigned ADC_BIT_CNT_W = 4;

   typedef logic [ADC_WORD_W-1:0]    adc_word_t;
   typedef logic [ADC_BIT_CNT_W-1:0] adc_bit_cnt_t;

   // pattern_sel encodings
   localparam logic [1:0] PAT_USER = 2'd0;
   localparam logic [1:0] PAT_IDLE = 2'd1;
   localparam logic [1:0] PAT_RAMP = 2'd2;
   localparam logic [1:0] PAT_ALT  = 2'd3;

   // Alternating test words; phase 0 sends ADC_ALT_WORD_0
   localparam adc_word_t ADC_ALT_WORD_0 = 10'h2AA;
   localparam adc_word_t ADC_ALT_WORD_1 = 10'h155;

   // Last bit index of a frame, and the number of bit times frame_clk stays high
   localparam adc_bit_cnt_t ADC_BIT_LAST  = adc_bit_cnt_t'(ADC_WORD_W - 1);
   localparam adc_bit_cnt_t ADC_FCLK_HIGH = adc_bit_cnt_t'(ADC_WORD_W / 2);

endpackage

// File: rtl/adc_lane_shifter.sv
// adc_lane_shifter
//   One serial lane: a word-wide load/shift register sent MSB first.
//   Ports:
//     data_clk  in  bit clock
//     reset     in  synchronous active-high reset
//     load      in  load load_word (highest priority after reset/clear)
//     shift     in  shift left by one, zero fill
//     clear     in  synchronous clear (used when the frame ends and the link goes idle)
//     load_word in  parallel word to load
//     msb       out current serial bit (register bit, no logic after it)
module adc_lane_shifter
   import adc_link_pkg::*;
(
   input  logic      data_clk,
   input  logic      reset,
   input  logic      load,
   input  logic      shift,
   input  logic      clear,
   input  adc_word_t load_word,
   output logic      msb
);

   adc_word_t r_shift;

   always_ff @(posedge data_clk) begin
      if (reset || clear) begin
         r_shift <= '0;
      end else if (load) begin
         r_shift <= load_word;
      end else if (shift) begin
         r_shift <= {r_shift[ADC_WORD_W-2:0], 1'b0};
      end
   end

   assign msb = r_shift[ADC_WORD_W-1];

endmodule

// File: rtl/adc_serializer.sv
// adc_serializer
//   Four-lane, 10-bit, MSB-first serial transmitter emulating the DAQ ADC front end.
//   Frame clock is high for bits 9..5 and low for bits 4..0 of every word.
//   Ports:
//     data_clk          in   bit clock (one bit per rising edge)
//     reset             in   synchronous active-high reset
//     enable            in   start/stop; only acted on at frame boundaries
//     pattern_sel       in   0 user, 1 IDLE_WORD, 2 ramp, 3 alternating 2AA/155
//     word_a..word_d    in   parallel sample set
//     word_valid        in   sample set valid
//     word_ready        out  one-entry holding register is empty
//     data_a..data_d    out  serial lanes
//     frame_clk         out  frame marker
//     busy              out  transmitter is running
//     underrun_count    out  saturating count of user-mode frames with no data
module adc_serializer
   import adc_link_pkg::*;
#(
   parameter adc_word_t   IDLE_WORD = 10'h000,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             data_clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [1:0]       pattern_sel,
   input  adc_word_t        word_a,
   input  adc_word_t        word_b,
   input  adc_word_t        word_c,
   input  adc_word_t        word_d,
   input  logic             word_valid,
   output logic             word_ready,
   output logic             data_a,
   output logic             data_b,
   output logic             data_c,
   output logic             data_d,
   output logic             frame_clk,
   output logic             busy,
   output logic [CNT_W-1:0] underrun_count
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]         r_state;
   adc_bit_cnt_t       r_bit_cnt;
   logic               r_frame_clk;
   logic               r_full;
   adc_word_t          r_hold [ADC_LANES];
   adc_word_t          r_ramp;
   logic               r_phase;
   logic [CNT_W-1:0]   r_underrun;

   logic [0:0]         w_state_d;
   adc_bit_cnt_t       w_bit_cnt_d;
   logic               w_load;
   logic               w_shift;
   logic               w_clear;
   logic               w_accept;
   logic               w_take;
   logic               w_underrun;
   adc_word_t          w_load_word [ADC_LANES];
   logic [ADC_LANES-1:0] w_msb;

   // Frame sequencing: a load edge starts every frame, the other nine edges shift.
   always_comb begin
      w_state_d   = r_state;
      w_bit_cnt_d = r_bit_cnt;
      w_load      = 1'b0;
      w_shift     = 1'b0;
      w_clear     = 1'b0;
      if (r_state == ST_IDLE) begin
         if (enable) begin
            w_state_d   = ST_RUN;
            w_bit_cnt_d = '0;
            w_load      = 1'b1;
         end
      end else if (r_bit_cnt == ADC_BIT_LAST) begin
         w_bit_cnt_d = '0;
         if (enable) begin
            w_load = 1'b1;
         end else begin
            // Frame is complete; drop the lanes to 0 for IDLE
            w_state_d = ST_IDLE;
            w_clear   = 1'b1;
         end
      end else begin
         w_bit_cnt_d = r_bit_cnt + 1'b1;
         w_shift     = 1'b1;
      end
   end

   // Holding register handshake. Acceptance needs empty and take needs full, so they
   // never coincide; a word arriving on a load edge waits for the next frame.
   assign w_accept   = word_valid && !r_full;
   assign w_take     = w_load && (pattern_sel == PAT_USER) && r_full;
   assign w_underrun = w_load && (pattern_sel == PAT_USER) && !r_full;

   always_comb begin
      for (int k = 0; k < ADC_LANES; k++) begin
         w_load_word[k] = IDLE_WORD;
         case (pattern_sel)
            PAT_USER: w_load_word[k] = r_full ? r_hold[k] : IDLE_WORD;
            PAT_IDLE: w_load_word[k] = IDLE_WORD;
            PAT_RAMP: w_load_word[k] = r_ramp + adc_word_t'(k);
            PAT_ALT:  w_load_word[k] = r_phase ? ADC_ALT_WORD_1 : ADC_ALT_WORD_0;
            default:  w_load_word[k] = IDLE_WORD;
         endcase
      end
   end

   always_ff @(posedge data_clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_bit_cnt   <= '0;
         r_frame_clk <= 1'b0;
         r_full      <= 1'b0;
         r_hold      <= '{default: '0};
         r_ramp      <= '0;
         r_phase     <= 1'b0;
         r_underrun  <= '0;
      end else begin
         r_state     <= w_state_d;
         r_bit_cnt   <= w_bit_cnt_d;
         // Registered so frame_clk lines up with the MSB leaving the shifters
         r_frame_clk <= (w_state_d == ST_RUN) && (w_bit_cnt_d < ADC_FCLK_HIGH);

         if (w_accept) begin
            r_full    <= 1'b1;
            r_hold[0] <= word_a;
            r_hold[1] <= word_b;
            r_hold[2] <= word_c;
            r_hold[3] <= word_d;
         end else if (w_take) begin
            r_full <= 1'b0;
         end

         if (w_underrun && (r_underrun != '1)) begin
            r_underrun <= r_underrun + 1'b1;
         end

         if (w_load && (pattern_sel == PAT_RAMP)) begin
            r_ramp <= r_ramp + 1'b1;
         end

         if (w_load && (pattern_sel == PAT_ALT)) begin
            r_phase <= ~r_phase;
         end
      end
   end

   for (genvar g = 0; g < ADC_LANES; g++) begin : g_lane
      adc_lane_shifter u_shifter (
         .data_clk  (data_clk),
         .reset     (reset),
         .load      (w_load),
         .shift     (w_shift),
         .clear     (w_clear),
         .load_word (w_load_word[g]),
         .msb       (w_msb[g])
      );
   end

   assign data_a         = w_msb[0];
   assign data_b         = w_msb[1];
   assign data_c         = w_msb[2];
   assign data_d         = w_msb[3];
   assign frame_clk      = r_frame_clk;
   assign busy           = r_state;
   assign word_ready     = ~r_full;
   assign underrun_count = r_underrun;

endmodule

// File: tb/tb_adc_serializer.sv
module tb_adc_serializer;
   import adc_link_pkg::*;

   logic        data_clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [1:0]  psel = PAT_USER;
   logic [9:0]  wa = '0, wb = '0, wc = '0, wd = '0;
   logic        valid = 1'b0;
   logic        word_ready, data_a, data_b, data_c, data_d, frame_clk, busy;
   logic [15:0] underrun_count;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural reference: frame-level view (current word per lane + bit position)
   bit         m_run = 0, m_full = 0, m_phase = 0;
   int         m_pos = 0, m_ramp = 0, m_under = 0;
   logic [9:0] m_cur [4];
   logic [9:0] m_hold [4];

   adc_serializer #(
      .IDLE_WORD (10'h000),
      .CNT_W     (16)
   ) dut (
      .data_clk       (data_clk),
      .reset          (rst),
      .enable         (en),
      .pattern_sel    (psel),
      .word_a         (wa),
      .word_b         (wb),
      .word_c         (wc),
      .word_d         (wd),
      .word_valid     (valid),
      .word_ready     (word_ready),
      .data_a         (data_a),
      .data_b         (data_b),
      .data_c         (data_c),
      .data_d         (data_d),
      .frame_clk      (frame_clk),
      .busy           (busy),
      .underrun_count (underrun_count)
   );

   always #5 data_clk = ~data_clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: got no summary, required run to finish");
      $fatal(1, "watchdog expired");
   end

   task automatic model_edge();
      bit accept;
      bit load;
      if (rst) begin
         m_run = 0; m_full = 0; m_phase = 0; m_pos = 0; m_ramp = 0; m_under = 0;
         for (int k = 0; k < 4; k++) begin m_cur[k] = '0; m_hold[k] = '0; end
         return;
      end
      accept = valid && !m_full;
      load = 0;
      if (!m_run) begin
         if (en) begin load = 1; m_run = 1; end
      end else if (m_pos == 9) begin
         m_pos = 0;
         if (en) load = 1;
         else m_run = 0;
      end else begin
         m_pos++;
      end
      if (load) begin
         m_pos = 0;
         for (int k = 0; k < 4; k++) begin
            case (psel)
               PAT_USER: m_cur[k] = m_full ? m_hold[k] : 10'h000;
               PAT_IDLE: m_cur[k] = 10'h000;
               PAT_RAMP: m_cur[k] = 10'((m_ramp + k) % 1024);
               default:  m_cur[k] = m_phase ? 10'h155 : 10'h2AA;
            endcase
         end
         if (psel == PAT_USER) begin
            if (m_full) m_full = 0;
            else if (m_under < 65535) m_under++;
         end
         if (psel == PAT_RAMP) m_ramp = (m_ramp + 1) % 1024;
         if (psel == PAT_ALT) m_phase = !m_phase;
      end
      if (accept) begin
         m_full = 1;
         m_hold[0] = wa; m_hold[1] = wb; m_hold[2] = wc; m_hold[3] = wd;
      end
   endtask

   task automatic step();
      @(posedge data_clk);
      model_edge();
      #1;
   endtask

   // {lanes a..d, frame_clk, busy, word_ready}
   function automatic logic [6:0] exp_vec();
      logic [3:0] l;
      for (int k = 0; k < 4; k++) l[3-k] = m_run ? m_cur[k][9-m_pos] : 1'b0;
      return {l, m_run && (m_pos < 5), m_run, !m_full};
   endfunction

   function automatic logic [6:0] obs_vec();
      return {data_a, data_b, data_c, data_d, frame_clk, busy, word_ready};
   endfunction

   task automatic set_words(input logic [9:0] a, input logic [9:0] b,
                            input logic [9:0] c, input logic [9:0] d);
      wa = a; wb = b; wc = c; wd = d;
   endtask

   task automatic do_reset();
      rst = 1; en = 0; valid = 0;
      step();
      rst = 0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (obs_vec() !== 7'b0000_001) begin
         n_errors++; $display("FAIL reset_vals: got %b expected %b", obs_vec(), 7'b0000_001);
      end
      for (int c = 0; c < 20; c++) begin
         step();
         n_checks++;
         if (obs_vec() !== 7'b0000_001 || underrun_count !== 16'd0) begin
            n_errors++;
            $display("FAIL idle c=%0d: got %b/%0d expected 0000001/0", c, obs_vec(), underrun_count);
         end
      end
   endtask

   task automatic test_user_data();
      logic [9:0] exp_w [4];
      logic [9:0] rx [4];
      logic [9:0] fpat;
      exp_w = '{10'h3FF, 10'h000, 10'h2AA, 10'h155};
      do_reset();
      psel = PAT_USER;
      set_words(exp_w[0], exp_w[1], exp_w[2], exp_w[3]);
      valid = 1; step(); valid = 0;
      n_checks++;
      if (word_ready !== 1'b0) begin
         n_errors++; $display("FAIL ud_ready_fall: got %b expected 0", word_ready);
      end
      en = 1; step();
      for (int j = 0; j < 10; j++) begin
         n_checks++;
         if (obs_vec() !== exp_vec()) begin
            n_errors++; $display("FAIL ud_cycle j=%0d: got %b expected %b", j, obs_vec(), exp_vec());
         end
         fpat[9-j] = frame_clk;
         rx[0][9-j] = data_a; rx[1][9-j] = data_b; rx[2][9-j] = data_c; rx[3][9-j] = data_d;
         if (j == 9) en = 0;
         step();
      end
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (rx[k] !== exp_w[k]) begin
            n_errors++; $display("FAIL ud_word lane=%0d: got %h expected %h", k, rx[k], exp_w[k]);
         end
      end
      n_checks++;
      if (fpat !== 10'b11111_00000) begin
         n_errors++; $display("FAIL ud_fclk: got %b expected 1111100000", fpat);
      end
      n_checks++;
      if (obs_vec() !== 7'b0000_001) begin
         n_errors++; $display("FAIL ud_stopped: got %b expected 0000001", obs_vec());
      end
   endtask

   task automatic test_underrun();
      logic [9:0] w1 [4];
      logic [9:0] w2 [4];
      logic [9:0] rx [4];
      for (int k = 0; k < 4; k++) begin w1[k] = 10'($urandom); w2[k] = 10'($urandom); end
      do_reset();
      psel = PAT_USER;
      set_words(w1[0], w1[1], w1[2], w1[3]);
      en = 1; step();
      for (int c = 0; c < 30; c++) begin
         n_checks++;
         if (obs_vec() !== exp_vec() || underrun_count !== 16'(m_under)) begin
            n_errors++;
            $display("FAIL un_cycle c=%0d: got %b/%0d expected %b/%0d", c, obs_vec(),
                     underrun_count, exp_vec(), m_under);
         end
         valid = (c == 24);
         step();
      end
      n_checks++;
      if (underrun_count !== 16'd3) begin
         n_errors++; $display("FAIL un_count3: got %0d expected 3", underrun_count);
      end
      set_words(w2[0], w2[1], w2[2], w2[3]);
      for (int j = 0; j < 10; j++) begin
         n_checks++;
         if (obs_vec() !== exp_vec()) begin
            n_errors++; $display("FAIL un_f4 j=%0d: got %b expected %b", j, obs_vec(), exp_vec());
         end
         rx[0][9-j] = data_a; rx[1][9-j] = data_b; rx[2][9-j] = data_c; rx[3][9-j] = data_d;
         valid = (j == 9);  // arrives on the load edge: no bypass
         step();
      end
      valid = 0;
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (rx[k] !== w1[k]) begin
            n_errors++; $display("FAIL un_word1 lane=%0d: got %h expected %h", k, rx[k], w1[k]);
         end
      end
      n_checks++;
      if (underrun_count !== 16'd4 || word_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL un_nobypass: got cnt=%0d ready=%b expected cnt=4 ready=0",
                  underrun_count, word_ready);
      end
      for (int j = 0; j < 10; j++) begin
         n_checks++;
         if (obs_vec() !== exp_vec()) begin
            n_errors++; $display("FAIL un_f5 j=%0d: got %b expected %b", j, obs_vec(), exp_vec());
         end
         if (j < 9) begin
            n_checks++;
            if ({data_a, data_b, data_c, data_d} !== 4'b0000) begin
               n_errors++; $display("FAIL un_idle_word j=%0d: got %b expected 0000", j,
                                    {data_a, data_b, data_c, data_d});
            end
         end
         step();
      end
      for (int j = 0; j < 10; j++) begin
         rx[0][9-j] = data_a; rx[1][9-j] = data_b; rx[2][9-j] = data_c; rx[3][9-j] = data_d;
         if (j == 9) en = 0;
         step();
      end
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (rx[k] !== w2[k]) begin
            n_errors++; $display("FAIL un_word2 lane=%0d: got %h expected %h", k, rx[k], w2[k]);
         end
      end
   endtask

   task automatic test_ramp();
      logic [9:0] rx [4];
      logic [9:0] want;
      do_reset();
      psel = PAT_RAMP;
      en = 1; step();
      for (int f = 0; f < 1030; f++) begin
         for (int j = 0; j < 10; j++) begin
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
               n_errors++;
               $display("FAIL ramp_cycle f=%0d j=%0d: got %b expected %b", f, j, obs_vec(), exp_vec());
            end
            rx[0][9-j] = data_a; rx[1][9-j] = data_b; rx[2][9-j] = data_c; rx[3][9-j] = data_d;
            if (f == 1029 && j == 9) en = 0;
            step();
         end
         for (int k = 0; k < 4; k++) begin
            want = 10'((f + k) % 1024);
            n_checks++;
            if (rx[k] !== want) begin
               n_errors++; $display("FAIL ramp_word f=%0d lane=%0d: got %h expected %h", f, k, rx[k], want);
            end
         end
      end
   endtask

   task automatic test_stop_alt();
      logic [9:0] rx [4];
      logic [9:0] want;
      do_reset();
      psel = PAT_IDLE;
      set_words(10'($urandom), 10'($urandom), 10'($urandom), 10'($urandom));
      en = 1; step();
      for (int f = 0; f < 5; f++) begin
         for (int j = 0; j < 10; j++) begin
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
               n_errors++;
               $display("FAIL alt_cycle f=%0d j=%0d: got %b expected %b", f, j, obs_vec(), exp_vec());
            end
            rx[0][9-j] = data_a; rx[1][9-j] = data_b; rx[2][9-j] = data_c; rx[3][9-j] = data_d;
            valid = (f == 0 && j == 2);
            if (f == 0 && j == 9) psel = PAT_ALT;
            if (f == 4 && j == 3) en = 0;  // mid-frame: frame must still complete
            step();
         end
         if (f == 0) want = 10'h000;
         else if ((f - 1) % 2 == 0) want = 10'h2AA;
         else want = 10'h155;
         for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (rx[k] !== want) begin
               n_errors++; $display("FAIL alt_word f=%0d lane=%0d: got %h expected %h", f, k, rx[k], want);
            end
         end
      end
      // Holding register is untouched outside user mode, so it is still full
      n_checks++;
      if (obs_vec() !== 7'b0000_000) begin
         n_errors++; $display("FAIL alt_stopped: got %b expected 0000000", obs_vec());
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [9:0] rx [4];
      do_reset();
      psel = PAT_USER;
      set_words(10'($urandom), 10'($urandom), 10'($urandom), 10'($urandom));
      en = 1; step();
      for (int j = 0; j < 7; j++) begin
         n_checks++;
         if (obs_vec() !== exp_vec()) begin
            n_errors++; $display("FAIL rmf_cycle j=%0d: got %b expected %b", j, obs_vec(), exp_vec());
         end
         valid = (j == 1);
         if (j == 6) rst = 1;
         step();
      end
      rst = 0;
      n_checks++;
      if (obs_vec() !== 7'b0000_001 || underrun_count !== 16'd0) begin
         n_errors++;
         $display("FAIL rmf_vals: got %b/%0d expected 0000001/0", obs_vec(), underrun_count);
      end
      // Ramp must restart from 0 after reset
      psel = PAT_RAMP;
      en = 1; step();
      for (int j = 0; j < 10; j++) begin
         rx[0][9-j] = data_a; rx[1][9-j] = data_b; rx[2][9-j] = data_c; rx[3][9-j] = data_d;
         if (j == 9) en = 0;
         step();
      end
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (rx[k] !== 10'(k)) begin
            n_errors++; $display("FAIL rmf_ramp lane=%0d: got %h expected %h", k, rx[k], 10'(k));
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [9:0] sets [8][4];
      logic [9:0] rx [4];
      int idx;
      int dly;
      for (int i = 0; i < 8; i++)
         for (int k = 0; k < 4; k++) sets[i][k] = 10'($urandom);
      do_reset();
      psel = PAT_USER;
      set_words(sets[0][0], sets[0][1], sets[0][2], sets[0][3]);
      valid = 1; step(); valid = 0;
      en = 1; step();
      idx = 1;
      dly = $urandom_range(0, 8);
      for (int f = 0; f < 8; f++) begin
         for (int j = 0; j < 10; j++) begin
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
               n_errors++;
               $display("FAIL b2b_cycle f=%0d j=%0d: got %b expected %b", f, j, obs_vec(), exp_vec());
            end
            rx[0][9-j] = data_a; rx[1][9-j] = data_b; rx[2][9-j] = data_c; rx[3][9-j] = data_d;
            valid = 0;
            if (idx < 8 && !m_full) begin
               if (dly == 0) begin
                  valid = 1;
                  set_words(sets[idx][0], sets[idx][1], sets[idx][2], sets[idx][3]);
                  idx++;
                  dly = $urandom_range(0, 8);
               end else begin
                  dly--;
               end
            end
            if (f == 7 && j == 9) en = 0;
            step();
         end
         for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (rx[k] !== sets[f][k]) begin
               n_errors++;
               $display("FAIL b2b_word f=%0d lane=%0d: got %h expected %h", f, k, rx[k], sets[f][k]);
            end
         end
      end
      valid = 0;
      n_checks++;
      if (underrun_count !== 16'd0) begin
         n_errors++; $display("FAIL b2b_underrun: got %0d expected 0", underrun_count);
      end
   endtask

   initial begin
      test_reset();
      test_user_data();
      test_underrun();
      test_ramp();
      test_stop_alt();
      test_reset_mid_frame();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/adc_serializer.md
# adc_serializer

Four-lane, 10-bit, MSB-first serial transmitter that produces the same serial format the DAQ ADC front end consumes: four data lanes plus a frame clock that is high for bits 9..5 and low for bits 4..0 of each word. It is the other end of the ADC deserializer. It runs on the bit clock, accepts parallel sample sets through a valid/ready handshake, and can generate built-in test patterns. It serves as the ADC emulator for loopback tests and for bench characterisation of the DAQ receive path.

## Interface

- `IDLE_WORD`, 10'h000: word sent on all lanes when there is no data, and in pattern mode 1.
- `CNT_W`, 16: width of the underrun counter.

Ports (name, direction, width, meaning):

- `data_clk` in 1: bit clock, the only clock. Single data rate, one bit per rising edge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: start or stop transmission. Sampled at frame boundaries.
- `pattern_sel` in 2: word source. 0 = user data, 1 = `IDLE_WORD`, 2 = ramp, 3 = alternating 10'h2AA/10'h155.
- `word_a`, `word_b`, `word_c`, `word_d` in 10 each: parallel sample set.
- `word_valid` in 1: the sample set is valid.
- `word_ready` out 1: the holding register is empty.
- `data_a`, `data_b`, `data_c`, `data_d` out 1: serial lanes.
- `frame_clk` out 1: frame marker.
- `busy` out 1: the block is in the RUN state.
- `underrun_count` out `CNT_W`: saturating count of user-mode frames that had no data.

## Operation

- **Holding register (one entry, 4×10 bits plus a full flag).**
  - `word_ready` = !full, taken directly from the register.
  - A transfer occurs when `word_valid && word_ready` on a clock edge; the entry becomes full.
- **States: IDLE, RUN.**
  - IDLE: all lanes are 0, `frame_clk` = 0, `bit_cnt` = 0.
  - IDLE → RUN on an edge where `enable` = 1. That edge performs a load.
  - RUN → IDLE on an edge where `bit_cnt` = 9 and `enable` = 0. The current frame always completes.
  - Otherwise RUN continues, and the edge at `bit_cnt` = 9 is a load edge.
- **Load edge.**
  - `bit_cnt` ← 0.
  - The shift registers are loaded per `pattern_sel`, which is sampled only on load edges.
- **Other RUN edges.**
  - `bit_cnt` ← `bit_cnt` + 1.
  - Each shift register shifts left by one.
- **Load sources.**
  - Mode 0, holding register full: load `word_a`..`word_d` from the entry and clear full.
  - Mode 0, holding register empty: load `IDLE_WORD` on all lanes and increment `underrun_count`, saturating at all-ones.
  - Mode 1: `IDLE_WORD` on all lanes.
  - Mode 2: lane k gets (`ramp` + k) mod 1024, then `ramp` ← `ramp` + 1 mod 1024. `ramp` resets to 0.
  - Mode 3: all lanes get 10'h2AA on the first mode-3 frame, then 10'h155, alternating. The phase bit resets to 0 (0 = 10'h2AA).
  - In modes 1–3 the holding register is not touched; handshakes still fill it.
- **Outputs.**
  - `data_x` = bit 9 of the lane's shift register.
  - `frame_clk` = (`bit_cnt` < 5) && RUN.
  - `busy` = RUN.
  - All outputs come from registers only.
- **Boundary cases.**
  - Full holding register at a load edge: no transfer can happen that edge, because `word_ready` = 0.
  - Empty holding register at a load edge with `word_valid` = 1: the word goes into the holding register, not the shift register. The frame sends `IDLE_WORD` and counts an underrun. There is no bypass path.
  - `enable` toggling mid-frame has no effect until `bit_cnt` = 9.
  - `reset` mid-frame: on the next edge every register clears, including the holding register, `ramp`, the phase bit and `underrun_count`. The partial frame is lost.

## Timing

- **Reset values:** every lane = 0, `frame_clk` = 0, `busy` = 0, `word_ready` = 1, `underrun_count` = 0.
- **Frame period:** 10 `data_clk` cycles.
- **Frame timing:** `frame_clk` is high for 5 cycles and low for 5. Its rising edge coincides with bit 9 (the MSB) appearing on all lanes.
- **Start-up:** after the IDLE → RUN edge, the MSB is visible in that same cycle (registered outputs).
- **Latency:** a word accepted at edge t while RUN and empty appears starting at the next load edge. This is at most 10 cycles after t.
- **Handshake rate:** `word_ready` falls the cycle after acceptance and rises the cycle after the load edge. Sustained throughput is one word per 10 cycles with no underrun, provided the source responds within 9 cycles of `word_ready` rising.

## Structure

- Shared package `adc_link_pkg` holds:
  - `ADC_WORD_W` = 10 and `ADC_LANES` = 4;
  - the `pattern_sel` encodings `PAT_USER`, `PAT_IDLE`, `PAT_RAMP`, `PAT_ALT`;
  - the constants 10'h2AA and 10'h155.

  The deserializer and bench share these.
- Sub-module `adc_lane_shifter` (one per lane): a 10-bit load/shift register with output `msb`. The top level holds the holding register, the state machine, `bit_cnt`, the pattern generators and the counter.

## Test plan

- **Reset and idle:** reset, `enable` = 0 for 20 cycles → all lanes 0, `frame_clk` 0, `busy` 0, `word_ready` 1.
- **User data:** mode 0; push a=10'h3FF, b=10'h000, c=10'h2AA, d=10'h155, then `enable`=1 → lanes serialise MSB first. `frame_clk` pattern is 1111100000. The deserializer loopback recovers the same four words.
- **Underrun:** mode 0, `enable`=1, no words for 3 frames → `IDLE_WORD` is sent and `underrun_count` = 3. Push one word → it appears on the next frame and the count stays at 3.
- **Ramp:** mode 2 for 1030 frames → lane a shows 0,1,…,1023,0,…,5. Lanes b, c, d show offsets +1, +2, +3 mod 1024 (lane d, first frame = 3).
- **Stop and alternate:** mode 3; deassert `enable` at `bit_cnt` = 3 → the frame completes, then `busy`=0. Words alternate 2AA/155 from frame one.
- **Reset mid-frame:** assert `reset` at `bit_cnt` = 6 with the holding register full → the next cycle shows all reset values and the holding register is empty (`word_ready` = 1).
